// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter between two byte requesters.
//   req0 = sequencer result stream, req1 = register-print message stream.
//   Each requester has a small FIFO of {last, data} entries. A frame-aware
//   round-robin arbiter drains them one byte at a time; strobes are paced on
//   the transmitter busy flag. Frames never interleave.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_reqN_data/valid/last    requester N byte, write strobe, end-of-frame
//   o_reqN_full, o_reqN_ovf   FIFO N full, sticky overflow (cleared by rst)
//   i_tx_busy                 transmitter busy
//   o_tx_data, o_tx_stb       byte to transmitter, 1-cycle send strobe
//   o_grant                   requester owning the current frame
//   o_active                  frame in progress

// Per-requester FIFO. A write while full is dropped and flags ovf.
module uart_tx_arb_fifo #(
    parameter int W  = 9,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr,
    input  logic         rd,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full,
    output logic         ovf
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW:0]             wp, rp;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr && !full)
            mem[wp[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr && !full) wp <= wp + 1'b1;
            if (wr && full)  ovf <= 1'b1;
            if (rd && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

module uart_tx_arb #(
    parameter int DW       = 8,
    parameter int FIFO_AW  = 2,
    parameter int BUSY_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_req0_data,
    input  logic          i_req0_valid,
    input  logic          i_req0_last,
    output logic          o_req0_full,
    output logic          o_req0_ovf,
    input  logic [DW-1:0] i_req1_data,
    input  logic          i_req1_valid,
    input  logic          i_req1_last,
    output logic          o_req1_full,
    output logic          o_req1_ovf,
    input  logic          i_tx_busy,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_stb,
    output logic          o_grant,
    output logic          o_active
);
    localparam int CW = $clog2(BUSY_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t            state, state_nx;
    logic [1:0][DW:0]  fifo_wdata, fifo_rdata;
    logic [1:0]        fifo_wr, fifo_rd, fifo_empty, fifo_full, fifo_ovf;
    logic              lock, rr, last_sent, sel, can_pop, lo_done;
    logic [CW-1:0]     cnt;

    assign fifo_wdata[0] = {i_req0_last, i_req0_data};
    assign fifo_wdata[1] = {i_req1_last, i_req1_data};
    assign fifo_wr       = {i_req1_valid, i_req0_valid};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        uart_tx_arb_fifo #(.W(DW + 1), .AW(FIFO_AW)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_data (fifo_wdata[gi]),
            .wr      (fifo_wr[gi]),
            .rd      (fifo_rd[gi]),
            .rd_data (fifo_rdata[gi]),
            .empty   (fifo_empty[gi]),
            .full    (fifo_full[gi]),
            .ovf     (fifo_ovf[gi])
        );
    end

    assign o_req0_full = fifo_full[0];
    assign o_req1_full = fifo_full[1];
    assign o_req0_ovf  = fifo_ovf[0];
    assign o_req1_ovf  = fifo_ovf[1];
    assign o_active    = (state != IDLE) || lock;

    // Source selection: a held lock pins the frame owner; otherwise the
    // single non-empty FIFO wins, or the RR pointer breaks a tie.
    always_comb begin
        sel = o_grant;
        if (!lock) begin
            if (!fifo_empty[0] && !fifo_empty[1]) sel = rr;
            else                                  sel = fifo_empty[0];
        end
    end

    assign can_pop = (state == IDLE) && !fifo_empty[sel] && !i_tx_busy;
    assign fifo_rd = can_pop ? (2'b01 << sel) : 2'b00;
    assign lo_done = (state == WAIT_LO) && !i_tx_busy;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (can_pop) state_nx = WAIT_HI;
            // Timeout covers a transmitter whose busy never rises.
            WAIT_HI: if (i_tx_busy || cnt == CW'(BUSY_LAT)) state_nx = WAIT_LO;
            WAIT_LO: if (!i_tx_busy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
            o_grant   <= 1'b0;
            lock      <= 1'b0;
            rr        <= 1'b0;
            last_sent <= 1'b0;
            cnt       <= '0;
        end else begin
            state    <= state_nx;
            o_tx_stb <= can_pop;
            if (can_pop) begin
                o_tx_data <= fifo_rdata[sel][DW-1:0];
                last_sent <= fifo_rdata[sel][DW];
                o_grant   <= sel;
                lock      <= 1'b1;
                cnt       <= '0;
            end else if (state == WAIT_HI) begin
                cnt <= cnt + 1'b1;
            end
            // Frame ends once its last byte has been accepted by the UART.
            if (lo_done && last_sent) begin
                lock <= 1'b0;
                rr   <= ~o_grant;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-based model of both FIFOs and the frame
// arbiter, checked every cycle, plus directed literal expectations.
module tb_uart_tx_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = 8'h0, d1 = 8'h0;
    logic       v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    logic       busy_m = 1'b0, busy_force = 1'b0, txb;
    logic       full0, ovf0, full1, ovf1, stb, grant, active;
    logic [7:0] tdata;

    always #5 clk = ~clk;
    assign txb = busy_m | busy_force;

    uart_tx_arb dut (
        .clk(clk), .rst(rst),
        .i_req0_data(d0), .i_req0_valid(v0), .i_req0_last(l0),
        .o_req0_full(full0), .o_req0_ovf(ovf0),
        .i_req1_data(d1), .i_req1_valid(v1), .i_req1_last(l1),
        .o_req1_full(full1), .o_req1_ovf(ovf1),
        .i_tx_busy(txb), .o_tx_data(tdata), .o_tx_stb(stb),
        .o_grant(grant), .o_active(active)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model state
    logic [8:0] q0[$], q1[$];
    bit   mlock = 0, mown = 0, mrr = 0, movf0 = 0, movf1 = 0;
    bit   p_rst = 1, p_v0 = 0, p_l0 = 0, p_v1 = 0, p_l1 = 0, prev_busy = 0;
    logic [7:0] p_d0 = 0, p_d1 = 0;
    int   cyc = 0;
    logic [7:0] log_d[$];
    bit   log_g[$];
    int   log_c[$];
    int   busy_h = 3;

    // Transmitter model: busy rises the cycle after a strobe, held busy_h cycles.
    initial begin
        int bcnt = 0;
        forever begin
            @(negedge clk);
            if (stb && busy_h > 0) bcnt = busy_h;
            @(posedge clk);
            #1;
            if (bcnt > 0) begin busy_m = 1'b1; bcnt--; end
            else busy_m = 1'b0;
        end
    end

    // Per-cycle compare. At negedge of cycle t: a strobe reflects a pop decided
    // on FIFO contents of cycle t-1, so it is resolved before applying the
    // writes captured at the same edge.
    initial begin
        bit f0b, f1b, g;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            f0b = q0.size() >= 4;
            f1b = q1.size() >= 4;
            if (p_rst) begin
                q0.delete(); q1.delete();
                mlock = 0; mown = 0; mrr = 0; movf0 = 0; movf1 = 0;
                chk("stb_after_rst", stb, 0);
            end else begin
                if (stb) begin
                    chk("stb_while_busy", prev_busy, 0);
                    if (mlock) g = mown;
                    else if (q0.size() != 0 && q1.size() != 0) g = mrr;
                    else g = (q0.size() == 0);
                    if ((g && q1.size() == 0) || (!g && q0.size() == 0)) begin
                        chk("stb_without_byte", stb, 0);
                    end else begin
                        e = g ? q1.pop_front() : q0.pop_front();
                        chk("tx_data", tdata, e[7:0]);
                        chk("grant", grant, g);
                        mown  = g;
                        mlock = !e[8];
                        if (e[8]) mrr = !g;
                    end
                    log_d.push_back(tdata);
                    log_g.push_back(grant);
                    log_c.push_back(cyc);
                end
                if (p_v0) begin if (f0b) movf0 = 1; else q0.push_back({p_l0, p_d0}); end
                if (p_v1) begin if (f1b) movf1 = 1; else q1.push_back({p_l1, p_d1}); end
            end
            chk("full0", full0, q0.size() >= 4);
            chk("full1", full1, q1.size() >= 4);
            chk("ovf0", ovf0, movf0);
            chk("ovf1", ovf1, movf1);
            prev_busy = txb;
            p_rst = rst; p_v0 = v0; p_l0 = l0; p_d0 = d0; p_v1 = v1; p_l1 = l1; p_d1 = d1;
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 0; v1 = 0;
        cyc_n(2);
        rst = 1'b0;
        cyc_n(1);
        log_d.delete(); log_g.delete(); log_c.delete();
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int k = 0;
        cyc_n(2);
        while (!(q0.size() == 0 && q1.size() == 0 && !active && !txb) && k < bound) begin
            cyc_n(1); k++;
        end
        chk(nm, k < bound, 1);
    endtask

    task automatic put(input bit r, input logic [7:0] d, input bit l);
        if (r) begin v1 = 1; d1 = d; l1 = l; end
        else   begin v0 = 1; d0 = d; l0 = l; end
    endtask

    initial begin
        int wc, n;
        logic [7:0] exp3[6];
        bit exg[6];
        bit dn0, dn1;
        exp3 = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
        exg  = '{0, 1, 0, 1, 0, 1};

        do_reset();
        chk("rst_stb", stb, 0);   chk("rst_data", tdata, 0);
        chk("rst_grant", grant, 0); chk("rst_active", active, 0);
        chk("rst_full", {full0, full1}, 0); chk("rst_ovf", {ovf0, ovf1}, 0);

        // 1: single byte latency
        busy_h = 3;
        wc = cyc + 1;
        put(0, 8'h41, 1); cyc_n(1); v0 = 0;
        wait_idle("t1_drain", 200);
        chk("t1_count", log_d.size(), 1);
        if (log_d.size() >= 1) begin
            chk("t1_latency", log_c[0] - wc, 2);
            chk("t1_data", log_d[0], 8'h41);
            chk("t1_grant", log_g[0], 0);
        end

        // 2: no preemption mid-frame
        log_d.delete(); log_g.delete(); log_c.delete();
        put(1, 8'h52, 0); cyc_n(1);
        put(1, 8'h30, 0); put(0, 8'h41, 1); cyc_n(1); v0 = 0;
        put(1, 8'h0A, 1); cyc_n(1); v1 = 0;
        wait_idle("t2_drain", 400);
        chk("t2_count", log_d.size(), 4);
        if (log_d.size() == 4)
            chk("t2_order", {log_d[0], log_d[1], log_d[2], log_d[3]}, 32'h52300A41);

        // 3: round-robin alternation, req0 first from reset
        do_reset();
        busy_force = 1;
        for (int i = 0; i < 3; i++) begin
            put(0, 8'(i + 1), 1); put(1, 8'(8'h11 + i), 1); cyc_n(1);
        end
        v0 = 0; v1 = 0; cyc_n(2);
        busy_force = 0;
        wait_idle("t3_drain", 600);
        chk("t3_count", log_d.size(), 6);
        if (log_d.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk("t3_data", log_d[i], exp3[i]);
                chk("t3_grant", log_g[i], exg[i]);
            end

        // 4: overflow while transmitter busy
        do_reset();
        busy_force = 1;
        for (int i = 0; i < 4; i++) begin put(0, 8'(8'hA0 + i), i == 3); cyc_n(1); end
        v0 = 0;
        chk("t4_full_after4", full0, 1);
        chk("t4_ovf_before", ovf0, 0);
        put(0, 8'hEE, 1); cyc_n(1); v0 = 0;
        chk("t4_ovf_after5", ovf0, 1);
        cyc_n(3);
        busy_force = 0;
        wait_idle("t4_drain", 400);
        chk("t4_count", log_d.size(), 4);
        if (log_d.size() == 4)
            chk("t4_order", {log_d[0], log_d[1], log_d[2], log_d[3]}, 32'hA0A1A2A3);

        // 5: busy never rises
        do_reset();
        busy_h = 0;
        for (int i = 0; i < 3; i++) begin put(1, 8'(8'h60 + i), 1); cyc_n(1); end
        v1 = 0;
        wait_idle("t5_drain", 200);
        chk("t5_count", log_d.size(), 3);
        if (log_d.size() == 3) begin
            chk("t5_last", log_d[2], 8'h62);
            chk("t5_spacing", (log_c[1] - log_c[0] >= 3) && (log_c[1] - log_c[0] <= 8), 1);
        end

        // 6: reset during WAIT_LO with bytes queued
        do_reset();
        busy_h = 6;
        for (int i = 0; i < 4; i++) begin put(0, 8'(8'hC0 + i), 0); cyc_n(1); end
        v0 = 0;
        n = 0;
        while (!txb && n < 50) begin cyc_n(1); n++; end
        chk("t6_busy_seen", n < 50, 1);
        cyc_n(2);
        rst = 1; cyc_n(1);
        chk("t6_stb", stb, 0); chk("t6_data", tdata, 0); chk("t6_active", active, 0);
        chk("t6_grant", grant, 0); chk("t6_full", full0, 0);
        rst = 0;
        n = log_d.size();
        cyc_n(20);
        chk("t6_no_stb", log_d.size(), n);
        busy_h = 3;
        cyc_n(6);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 60 == 0) busy_h = $urandom_range(0, 4);
            busy_force = ($urandom_range(0, 15) == 0);
            v0 = ($urandom_range(0, 3) == 0); d0 = 8'($urandom); l0 = 1'($urandom);
            v1 = ($urandom_range(0, 3) == 0); d1 = 8'($urandom); l1 = 1'($urandom);
            cyc_n(1);
        end
        v0 = 0; v1 = 0; busy_force = 0;
        cyc_n(2);
        // Terminate every open frame so both FIFOs can drain.
        dn0 = 0; dn1 = 0; n = 0;
        while (!(dn0 && dn1) && n < 2000) begin
            v0 = 0; v1 = 0;
            if (!dn0 && q0.size() < 3) begin put(0, 8'h5A, 1); dn0 = 1; end
            if (!dn1 && q1.size() < 3) begin put(1, 8'hA5, 1); dn1 = 1; end
            cyc_n(1); n++;
        end
        v0 = 0; v1 = 0;
        chk("rand_close", dn0 && dn1, 1);
        wait_idle("rand_drain", 3000);
        chk("rand_q_empty", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
